// File: rtl/uart_arb_pkg.sv
// Shared types for the two-source UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_LAT,
        ST_SEND
    } arb_state_t;

    typedef logic src_idx_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: a tie goes to the source not served last.
module rr_arbiter2
    import uart_arb_pkg::*;
(
    input  logic [1:0] req,
    input  src_idx_t   last_served,
    output src_idx_t   grant
);

    always_comb begin
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_served;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Pops bytes from two FIFOs in round-robin bursts and presents them to a UART transmitter.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             fifo0_empty_i,
    output logic             fifo0_rd_en_o,
    input  logic [WIDTH-1:0] fifo0_rd_data_i,
    input  logic             fifo1_empty_i,
    output logic             fifo1_rd_en_o,
    input  logic [WIDTH-1:0] fifo1_rd_data_i,
    output logic [WIDTH-1:0] tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic             grant_o,
    output logic             busy_o
);

    localparam int             CW        = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0]  BURST_MAX = CW'(BURST_LEN);

    arb_state_t       state;
    src_idx_t         sel;
    src_idx_t         last_served;
    src_idx_t         rr_grant;
    logic [CW-1:0]    burst_cnt;
    logic [CW-1:0]    burst_inc;
    logic [1:0]       req;
    logic [1:0]       rd_en_q;
    logic             sel_empty;
    logic [WIDTH-1:0] tx_data_q;
    logic             tx_valid_q;
    logic             grant_q;
    logic             busy_q;

    assign req       = {~fifo1_empty_i, ~fifo0_empty_i};
    assign sel_empty = sel ? fifo1_empty_i : fifo0_empty_i;
    assign burst_inc = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + CW'(1);

    rr_arbiter2 u_rr_arbiter2 (
        .req         (req),
        .last_served (last_served),
        .grant       (rr_grant)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            sel         <= 1'b0;
            last_served <= 1'b1;
            burst_cnt   <= '0;
            rd_en_q     <= 2'b00;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            grant_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        sel     <= rr_grant;
                        grant_q <= rr_grant;
                        rd_en_q <= rr_grant ? 2'b10 : 2'b01;
                        busy_q  <= 1'b1;
                        state   <= ST_POP;
                    end
                end
                // A pop is only issued against a non-empty FIFO; if it drained, abandon.
                ST_POP: begin
                    rd_en_q <= 2'b00;
                    if (sel_empty) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        state  <= ST_LAT;
                    end
                end
                ST_LAT: begin
                    tx_data_q  <= sel ? fifo1_rd_data_i : fifo0_rd_data_i;
                    tx_valid_q <= 1'b1;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_ready_i) begin
                        tx_valid_q <= 1'b0;
                        if (burst_inc < BURST_MAX && !sel_empty) begin
                            burst_cnt <= burst_inc;
                            rd_en_q   <= sel ? 2'b10 : 2'b01;
                            state     <= ST_POP;
                        end else begin
                            burst_cnt   <= '0;
                            last_served <= sel;
                            busy_q      <= 1'b0;
                            state       <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    rd_en_q    <= 2'b00;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo0_rd_en_o = rd_en_q[0] & ~fifo0_empty_i;
    assign fifo1_rd_en_o = rd_en_q[1] & ~fifo1_empty_i;
    assign tx_data_o     = tx_data_q;
    assign tx_valid_o    = tx_valid_q;
    assign grant_o       = grant_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with behavioural one-cycle-latency FIFO models.
module tb_uart_tx_arbiter;

    typedef struct {
        logic       src;
        logic [7:0] data;
    } sb_item_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fifo0_empty, fifo1_empty;
    logic       fifo0_rd_en, fifo1_rd_en;
    logic [7:0] fifo0_rd_data = 8'h00;
    logic [7:0] fifo1_rd_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       grant;
    logic       busy;

    logic [7:0] mem [2][64];
    int         wr_ptr [2] = '{0, 0};
    int         rd_ptr [2] = '{0, 0};
    sb_item_t   sb [$];

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;
    int popCyc      = 0;
    logic prevValid = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.WIDTH(8), .BURST_LEN(4)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .fifo0_empty_i   (fifo0_empty),
        .fifo0_rd_en_o   (fifo0_rd_en),
        .fifo0_rd_data_i (fifo0_rd_data),
        .fifo1_empty_i   (fifo1_empty),
        .fifo1_rd_en_o   (fifo1_rd_en),
        .fifo1_rd_data_i (fifo1_rd_data),
        .tx_data_o       (tx_data),
        .tx_valid_o      (tx_valid),
        .tx_ready_i      (tx_ready),
        .grant_o         (grant),
        .busy_o          (busy)
    );

    // FIFO models: data appears on rd_data the cycle after the pop.
    assign fifo0_empty = (wr_ptr[0] == rd_ptr[0]);
    assign fifo1_empty = (wr_ptr[1] == rd_ptr[1]);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo0_rd_en && !fifo0_empty) begin
            fifo0_rd_data <= mem[0][rd_ptr[0] % 64];
            rd_ptr[0]     <= rd_ptr[0] + 1;
        end
        if (fifo1_rd_en && !fifo1_empty) begin
            fifo1_rd_data <= mem[1][rd_ptr[1] % 64];
            rd_ptr[1]     <= rd_ptr[1] + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Loads one byte into a source FIFO and, if it will be transmitted, queues the expectation.
    task automatic applyStimulus(input int src, input logic [7:0] data, input bit expectTx);
        sb_item_t item;
        mem[src][wr_ptr[src] % 64] = data;
        wr_ptr[src] = wr_ptr[src] + 1;
        if (expectTx) begin
            item.src  = src[0];
            item.data = data;
            sb.push_back(item);
        end
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        repeat (2) @(negedge clk);
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", 32'(n >= budget), 32'd0);
    endtask

    task automatic waitValid(input int budget);
        int n = 0;
        while (!tx_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("valid_timeout", 32'(n >= budget), 32'd0);
    endtask

    // Monitor: protocol checks on pops and scoreboard compare on each completed handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevValid = 1'b0;
        end else begin
            if (fifo0_rd_en || fifo1_rd_en) begin
                checkOutput("rd_en_onehot", 32'(fifo0_rd_en & fifo1_rd_en), 32'd0);
                checkOutput("rd_en_nonempty",
                            32'((fifo0_rd_en & fifo0_empty) | (fifo1_rd_en & fifo1_empty)), 32'd0);
                popCyc = cyc;
            end
            if (tx_valid && !prevValid)
                checkOutput("latency", 32'(cyc - popCyc), 32'd2);
            if (tx_valid && tx_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_tx", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    sb_item_t exp;
                    exp = sb.pop_front();
                    checkOutput("tx_data", {24'd0, tx_data}, {24'd0, exp.data});
                    checkOutput("tx_grant", 32'(grant), 32'(exp.src));
                end
            end
            prevValid = tx_valid;
        end
    end

    initial begin
        rst_n    = 1'b0;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_data",  {24'd0, tx_data}, 32'd0);
        checkOutput("rst_rden",  32'({fifo1_rd_en, fifo0_rd_en}), 32'd0);
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_busy",  32'(busy), 32'd0);

        @(posedge clk); #2;
        rst_n = 1'b1;

        // Both sources full with 6 bytes: bursts of 4/4/2/2, source 0 first.
        $display("[TB] burst ordering");
        @(posedge clk); #2;
        tx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem[0][wr_ptr[0] % 64] = 8'h10 + 8'(i);
            wr_ptr[0] = wr_ptr[0] + 1;
            mem[1][wr_ptr[1] % 64] = 8'h20 + 8'(i);
            wr_ptr[1] = wr_ptr[1] + 1;
        end
        for (int i = 0; i < 4; i++) sb.push_back('{1'b0, 8'h10 + 8'(i)});
        for (int i = 0; i < 4; i++) sb.push_back('{1'b1, 8'h20 + 8'(i)});
        for (int i = 4; i < 6; i++) sb.push_back('{1'b0, 8'h10 + 8'(i)});
        for (int i = 4; i < 6; i++) sb.push_back('{1'b1, 8'h20 + 8'(i)});
        waitIdle(300);

        $display("[TB] single byte");
        @(posedge clk); #2;
        applyStimulus(0, 8'hA5, 1'b1);
        waitIdle(50);
        checkOutput("single_idle_busy", 32'(busy), 32'd0);

        // Receiver stalls for 10 cycles while a byte waits in SEND.
        $display("[TB] backpressure");
        @(posedge clk); #2;
        tx_ready = 1'b0;
        applyStimulus(0, 8'h3C, 1'b1);
        @(negedge clk);
        waitValid(20);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall_valid", 32'(tx_valid), 32'd1);
            checkOutput("stall_data", {24'd0, tx_data}, 32'h3C);
            checkOutput("stall_no_rden", 32'(fifo0_rd_en | fifo1_rd_en), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #2;
        tx_ready = 1'b1;
        waitIdle(50);

        $display("[TB] idle with empty sources");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_busy", 32'(busy), 32'd0);
            checkOutput("idle_rden", 32'(fifo0_rd_en | fifo1_rd_en), 32'd0);
        end

        // Reset during SEND drops the byte; afterwards the first tie goes to source 0.
        $display("[TB] reset mid-transfer");
        @(posedge clk); #2;
        tx_ready = 1'b0;
        applyStimulus(1, 8'h5A, 1'b0);
        @(negedge clk);
        waitValid(20);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(tx_valid), 32'd0);
        checkOutput("arst_data",  {24'd0, tx_data}, 32'd0);
        checkOutput("arst_rden",  32'({fifo1_rd_en, fifo0_rd_en}), 32'd0);
        checkOutput("arst_grant", 32'(grant), 32'd0);
        checkOutput("arst_busy",  32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        tx_ready = 1'b1;
        applyStimulus(0, 8'h61, 1'b1);
        applyStimulus(1, 8'h62, 1'b1);
        waitIdle(100);
        checkOutput("post_rst_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
